jtag_dr_frame: RTL
==================

Name: jtag_dr_frame

Overview:
- Downstream consumer of the BSCANE2 wrapper's TAP signals; implements the user data register behind the user JTAG chain.
- Deserialises a fixed-length DR frame (8-bit opcode + DATA_W data) shifted in on TDI and presents it as a one-cycle command.
- Serialises a status + response word out on TDO during the same DR scan.
- Runs entirely in the TCK domain; clock domain crossing to the fabric is done by a separate block.

Parameters:
- DATA_W, 32, width of command data and response data fields.
- OP_W, 8, opcode width (fixed by the shared package; exposed only for elaboration checks).
- STAT_W, 8, width of the status field prepended to the response on capture.

Ports:
- bscan_tck  in  1  TCK from the BSCANE2 wrapper; the only clock.
- tap_reset  in  1  synchronous, active-high reset (TAP Test-Logic-Reset).
- tap_capture  in  1  Capture-DR for this chain.
- tap_update  in  1  Update-DR for this chain.
- data_valid  in  1  shift & sel; one TDI bit per cycle while high.
- bscan_tdi  in  1  serial data in.
- bscan_tdo  out  1  serial data out, equal to shift_reg[0] (combinational from the register).
- rsp_data  in  DATA_W  response word loaded on capture.
- rsp_valid  in  1  response word is meaningful; reported in status bit 0.
- cmd_valid  out  1  one-cycle pulse when a good frame is committed.
- cmd_opcode  out  OP_W  opcode of the last committed frame.
- cmd_data  out  DATA_W  data of the last committed frame.
- err_flags  out  3  sticky {crc, long, short}.

Behaviour:
- FRAME_W = OP_W + DATA_W (+8 if CRC is enabled). The shift register is max(FRAME_W, STAT_W+DATA_W) bits.
- Reset (tap_reset=1 on a clock edge):
  - state=IDLE; shift_reg=0; bit_cnt=0.
  - cmd_valid=0; cmd_opcode=0; cmd_data=0; err_flags=0.
  - bscan_tdo=0.
  - Reset overrides every other input in the same cycle.
- States:
  - IDLE: capture -> CAPT.
  - CAPT: data_valid -> SHIFT; update -> IDLE.
  - SHIFT: update -> IDLE.
  - capture in any state -> CAPT.
- Capture cycle:
  - shift_reg <= {rsp_data, status}, status LSB first.
  - status[0]=rsp_valid, status[3:1]=err_flags, the rest 0.
  - bit_cnt <= 0.
  - err_flags are cleared on the same edge (read-to-clear); an error raised on that same edge wins.
- Shift cycle (data_valid=1):
  - shift_reg <= {bscan_tdi, shift_reg[MSB:1]}; the LSB goes out first.
  - bit_cnt increments and saturates at FRAME_W+1.
  - data_valid outside CAPT/SHIFT is ignored.
- Update cycle, evaluated only in CAPT or SHIFT:
  - Frame alignment: the frame is taken from the top FRAME_W bits. Opcode is the first OP_W bits shifted, data the following DATA_W bits.
  - bit_cnt == FRAME_W: cmd_opcode/cmd_data load, and cmd_valid=1 on the next cycle only.
  - bit_cnt < FRAME_W: set err short; no command.
  - bit_cnt > FRAME_W: set err long; no command.
  - bit_cnt == 0 (capture immediately followed by update): nothing happens, no error.
- Latency: cmd_valid is asserted in the cycle after update.
- Simultaneous events:
  - capture and update together: capture wins.
  - capture and data_valid together: capture wins, shift dropped.
- Reset mid-shift: partial frame discarded, no command, no error.
- cmd_opcode/cmd_data hold their value until the next good frame.

Optional Feature:
- Macro: JTAG_DR_FRAME_CRC_EN.
- With the macro defined:
  - An 8-bit CRC (poly 0x07, init 0x00, MSB-first over bits in shift order) follows the data; FRAME_W = OP_W+DATA_W+8.
  - The CRC is computed serially over the first OP_W+DATA_W shifted bits.
  - If the received CRC does not equal the computed CRC at a correct-length update: set err crc, no command.
- Without the macro: no CRC field, FRAME_W = OP_W+DATA_W, and err_flags[2] is tied to 0.

Decomposition:
- Package jtag_dr_pkg:
  - OP_W, STAT_W, CRC8_POLY.
  - Status bit indices (ST_RSP_VALID, ST_ERR_SHORT, ST_ERR_LONG, ST_ERR_CRC).
  - Error index constants and the state enum (IDLE, CAPT, SHIFT).
- One sub-module, jtag_crc8_serial:
  - Inputs: clk, clear, bit_en, bit.
  - Output: crc[7:0].
  - Instantiated only under JTAG_DR_FRAME_CRC_EN.

Test Plan:
- Reset, then capture with rsp_data=0xDEADBEEF and rsp_valid=1 -> the first 8 TDO bits are 0x01 LSB-first, the next 32 bits are 0xDEADBEEF LSB-first.
- Capture, shift 40 bits encoding opcode 0xA5 and data 0x12345678, then update -> one-cycle cmd_valid one cycle later, cmd_opcode=0xA5, cmd_data=0x12345678, err_flags=0.
- Capture, shift 39 bits, update -> no cmd_valid, err_flags=3'b001. The next capture shows status=0x03 and clears the flags.
- Capture, shift 45 bits, update -> no cmd_valid, err_flags=3'b010; cmd_opcode/cmd_data keep their previous values.
- Assert tap_reset after 20 shifted bits, then update -> no cmd_valid, err_flags=0, bscan_tdo=0.
- With JTAG_DR_FRAME_CRC_EN: send a 48-bit frame with a correct CRC -> command issued. Flip one data bit -> no command, err_flags=3'b100.

Source files
------------

// File: rtl/jtag_dr_pkg.sv
// Shared constants, status/error bit positions and FSM state type for the user JTAG DR.
package jtag_dr_pkg;

  localparam int OP_W   = 8;
  localparam int STAT_W = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Status word bit positions (status goes out first on TDO).
  localparam int ST_RSP_VALID = 0;
  localparam int ST_ERR_SHORT = 1;
  localparam int ST_ERR_LONG  = 2;
  localparam int ST_ERR_CRC   = 3;

  // err_flags bit positions: {crc, long, short}.
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_CRC   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    SHIFT = 2'd2
  } dr_state_e;

endpackage

// File: rtl/jtag_crc8_serial.sv
// Bit-serial CRC-8 (MSB-first shift, polynomial from jtag_dr_pkg, init 0x00).
module jtag_crc8_serial
  import jtag_dr_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       data_bit,
  output logic [7:0] crc
);

  logic fb;
  assign fb = data_bit ^ crc[7];

  always_ff @(posedge clk) begin
    if (clear) begin
      crc <= 8'h00;
    end else if (bit_en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/jtag_dr_frame.sv
// User JTAG data register: deserialises {opcode, data[, crc]} frames from TDI and shifts
// {rsp_data, status} out on TDO. Optional CRC-8 check enabled by JTAG_DR_FRAME_CRC_EN.
//
// state | meaning
// IDLE  | no scan in progress; shift and update ignored
// CAPT  | response/status just captured, no bits shifted yet
// SHIFT | shifting frame bits in / response bits out
module jtag_dr_frame
  import jtag_dr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8,
  parameter int STAT_W = 8
) (
  input  logic              bscan_tck,
  input  logic              tap_reset,
  input  logic              tap_capture,
  input  logic              tap_update,
  input  logic              data_valid,
  input  logic              bscan_tdi,
  output logic              bscan_tdo,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_valid,
  output logic              cmd_valid,
  output logic [OP_W-1:0]   cmd_opcode,
  output logic [DATA_W-1:0] cmd_data,
  output logic [2:0]        err_flags
);

`ifdef JTAG_DR_FRAME_CRC_EN
  localparam int CRC_W = 8;
`else
  localparam int CRC_W = 0;
`endif
  localparam int FRAME_W = OP_W + DATA_W + CRC_W;
  localparam int CAP_W   = STAT_W + DATA_W;
  localparam int SR_W    = (FRAME_W > CAP_W) ? FRAME_W : CAP_W;
  localparam int LSB_F   = SR_W - FRAME_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  if (OP_W != jtag_dr_pkg::OP_W) begin : g_op_w_check
    $error("jtag_dr_frame: OP_W must match jtag_dr_pkg::OP_W");
  end

  dr_state_e         state;
  logic [SR_W-1:0]   shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [STAT_W-1:0] status;
  logic              active;
  logic              shifting;
  logic              crc_ok;

  assign bscan_tdo = shift_reg[0];
  assign active    = (state == CAPT) || (state == SHIFT);
  // Update takes priority over a coincident shift; capture over both.
  assign shifting  = active && data_valid && !tap_capture && !tap_update;

  always_comb begin
    status               = '0;
    status[ST_RSP_VALID] = rsp_valid;
    status[ST_ERR_SHORT] = err_flags[ERR_SHORT];
    status[ST_ERR_LONG]  = err_flags[ERR_LONG];
    status[ST_ERR_CRC]   = err_flags[ERR_CRC];
  end

`ifdef JTAG_DR_FRAME_CRC_EN
  logic [7:0] crc_calc;
  logic       crc_en;

  // Only the opcode and data bits feed the CRC; the trailing CRC field does not.
  assign crc_en = shifting && (bit_cnt < CNT_W'(OP_W + DATA_W));

  jtag_crc8_serial u_crc (
    .clk      (bscan_tck),
    .clear    (tap_reset | tap_capture),
    .bit_en   (crc_en),
    .data_bit (bscan_tdi),
    .crc      (crc_calc)
  );

  assign crc_ok = (crc_calc == shift_reg[SR_W-1 -: 8]);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge bscan_tck) begin
    if (tap_reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= '0;
      cmd_data   <= '0;
      err_flags  <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (tap_capture) begin
        state     <= CAPT;
        shift_reg <= SR_W'({rsp_data, status});
        bit_cnt   <= '0;
        err_flags <= '0;
      end else if (active && tap_update) begin
        state <= IDLE;
        if (bit_cnt == CNT_W'(FRAME_W)) begin
          if (crc_ok) begin
            cmd_valid  <= 1'b1;
            cmd_opcode <= shift_reg[LSB_F +: OP_W];
            cmd_data   <= shift_reg[LSB_F + OP_W +: DATA_W];
          end else begin
            err_flags[ERR_CRC] <= 1'b1;
          end
        end else if (bit_cnt > CNT_W'(FRAME_W)) begin
          err_flags[ERR_LONG] <= 1'b1;
        end else if (bit_cnt != '0) begin
          err_flags[ERR_SHORT] <= 1'b1;
        end
      end else if (shifting) begin
        state     <= SHIFT;
        shift_reg <= {bscan_tdi, shift_reg[SR_W-1:1]};
        if (bit_cnt != CNT_W'(FRAME_W + 1)) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule
